// File: rtl/arb_pkg.sv
// Shared widths and FSM state type for the round-robin decode arbiter.
package arb_pkg;

  localparam int IDXW = 4;
  localparam int N    = 2 ** IDXW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec4x16_en.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module dec4x16_en
  import arb_pkg::*;
(
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [N-1:0]    onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter over 16 requesters: registered winner index, decoded to a
// one-hot grant, held until release, request drop or hold timeout.
module rr_dec_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  // owner-done strobe; "release" is a reserved word so it is named rel here
  input  logic            rel,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic            timeout_nxt;
  logic [N-1:0]    rot;
  logic [IDXW-1:0] pos;
  logic [IDXW-1:0] winner;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot = N'({req, req} >> ptr);
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDXW'(i);
    end
    winner = ptr + pos;
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = gnt_idx;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          idx_nxt   = winner;
          hold_nxt  = '0;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A release or request drop wins over the timeout on the same edge.
        if (rel || !req[gnt_idx]) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = gnt_idx + 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = ST_IDLE;
          ptr_nxt     = gnt_idx + 1'b1;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign gnt_vld = (state == ST_GRANT);

  dec4x16_en u_dec (
    .en     (gnt_vld),
    .idx    (gnt_idx),
    .onehot (gnt)
  );

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Randomized plus directed bench: a queue-based scoreboard fed by a spec-level
// arbitration model, drained by an independent monitor on the falling edge.
module tb_rr_dec_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic        rel = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: who owns the resource and for how many cycles.
  bit m_busy   = 1'b0;
  int m_idx    = 0;
  int m_ptr    = 0;
  int m_cycles = 0;
  bit m_to     = 1'b0;

  rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal("gnt", gnt, e.gnt);
    compareVal("gnt_idx", {12'd0, gnt_idx}, {12'd0, e.idx});
    compareVal("gnt_vld", {15'd0, gnt_vld}, {15'd0, e.vld});
    compareVal("timeout", {15'd0, timeout}, {15'd0, e.to});
  endtask

  // Advance the model across one clock edge and queue the outputs it predicts.
  task automatic modelStep(input logic [15:0] r, input logic rl, input logic rs);
    exp_t e;
    bit   found;
    if (rs) begin
      m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_cycles = 0; m_to = 1'b0;
    end else if (!m_busy) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && r[(m_ptr + k) % 16]) begin
          m_idx = (m_ptr + k) % 16;
          found = 1'b1;
        end
      end
      if (found) begin
        m_busy   = 1'b1;
        m_cycles = 1;
      end
    end else begin
      m_to = 1'b0;
      if (rl || !r[m_idx]) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 16;
      end else if (m_cycles == MAX_HOLD) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
        m_ptr  = (m_idx + 1) % 16;
      end else begin
        m_cycles++;
      end
    end
    e.gnt = m_busy ? (16'h0001 << m_idx) : 16'h0000;
    e.idx = 4'(m_idx);
    e.vld = m_busy;
    e.to  = m_to;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic rl, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      rst = 1'b0;
      req = r;
      rel = rl;
      modelStep(r, rl, 1'b0);
    end
  endtask

  task automatic doReset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      rst = 1'b1;
      req = '0;
      rel = 1'b0;
      modelStep(16'h0000, 1'b0, 1'b1);
    end
  endtask

  // Monitor: compare every presented output cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [15:0] r;
    doReset(2);

    // single requester, released after a couple of grant cycles
    applyStimulus(16'h0010, 1'b0, 3);
    applyStimulus(16'h0010, 1'b1, 1);
    applyStimulus(16'h0000, 1'b0, 3);

    // full round robin with an owner that releases immediately
    doReset(1);
    applyStimulus(16'hFFFF, 1'b1, 36);

    // wrap from ptr=14 and skip idle requesters
    doReset(1);
    applyStimulus(16'h2000, 1'b1, 2);
    applyStimulus(16'h0009, 1'b1, 8);

    // hold timeout and regrant to the same requester
    doReset(1);
    applyStimulus(16'h0100, 1'b0, 22);

    // release colliding with the final hold cycle, then a request drop
    doReset(1);
    applyStimulus(16'h0004, 1'b0, 8);
    applyStimulus(16'h0004, 1'b1, 1);
    applyStimulus(16'h0004, 1'b0, 3);
    applyStimulus(16'h0000, 1'b0, 3);

    // asynchronous reset while a grant is live
    doReset(1);
    applyStimulus(16'h0400, 1'b0, 2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    compareVal("async_rst_gnt", gnt, 16'h0000);
    compareVal("async_rst_vld", {15'd0, gnt_vld}, 16'h0000);
    modelStep(16'h0400, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 1'b1, 6);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 99) == 0) begin
        doReset(1);
      end else if ($urandom_range(0, 3) == 0) begin
        applyStimulus(16'hFFFF, 1'($urandom_range(0, 3) == 0), $urandom_range(1, 12));
      end else begin
        r = 16'($urandom) & 16'($urandom);
        applyStimulus(r, 1'($urandom_range(0, 3) == 0), $urandom_range(1, 4));
      end
    end

    applyStimulus(16'h0000, 1'b0, 2);
    @(negedge clk);
    @(negedge clk);
    compareVal("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
